// File: rtl/line_spi_reader_if.sv
// Signal bundle for line_spi_reader: SPI pins, SRAM read port and capture-status inputs.
// The reader uses the slave modport; the host/SRAM side uses the master modport.
interface line_spi_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              spi_clk;
  logic              cs;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-1:0] rdaddr;
  logic [DATA_W-1:0] rddata;
  logic              busy;
  logic [6:0]        frame_cnt;
  logic              active;

  modport slave (
    input  spi_clk, cs, spi_mosi, rddata, busy, frame_cnt,
    output spi_miso, rdaddr, active
  );

  modport master (
    output spi_clk, cs, spi_mosi, rddata, busy, frame_cnt,
    input  spi_miso, rdaddr, active
  );
endinterface

// File: rtl/line_spi_reader.sv
// SPI mode-0 slave giving a host read access to the line-buffer SRAM (READ 0x03 + 16-bit address).
// Optional STATUS command 0x05 is enabled by defining LSPI_STATUS_EN.
module line_spi_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input logic              clk,
  input logic              res_n,
  line_spi_reader_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, DATA, STAT, IGNORE
  } state_t;

  state_t            state;
  logic              sclk_p0, sclk_p1, sclk_p2;
  logic              cs_p0, cs_p1, cs_p2;
  logic              mosi_p0, mosi_p1, mosi_p2;
  logic [CNT_W-1:0]  bit_cnt;
  logic [14:0]       in_sh;
  logic [DATA_W-1:0] out_sh;
  logic [ADDR_W-1:0] rdaddr;
  logic              miso;
  logic              active;

  logic sclk_rise, sclk_fall, cs_fall, byte_end, word_end;

  // Edges come from stages 2/3; MOSI is taken from stage 3 so it lines up with the detected rise.
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign cs_fall   = ~cs_p1 & cs_p2;
  assign byte_end  = (bit_cnt == CNT_W'(7));
  assign word_end  = (bit_cnt == CNT_W'(DATA_W-1));

  assign bus.spi_miso = miso;
  assign bus.rdaddr   = rdaddr;
  assign bus.active   = active;

`ifndef LSPI_STATUS_EN
  logic unused_status;
  assign unused_status = ^{bus.busy, bus.frame_cnt};
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sclk_p0 <= 1'b0; sclk_p1 <= 1'b0; sclk_p2 <= 1'b0;
      cs_p0   <= 1'b0; cs_p1   <= 1'b0; cs_p2   <= 1'b0;
      mosi_p0 <= 1'b0; mosi_p1 <= 1'b0; mosi_p2 <= 1'b0;
      state   <= IDLE;
      bit_cnt <= '0;
      in_sh   <= '0;
      out_sh  <= '0;
      rdaddr  <= '0;
      miso    <= 1'b0;
      active  <= 1'b0;
    end else begin
      // synchroniser stage boundary
      sclk_p0 <= bus.spi_clk; sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
      cs_p0   <= bus.cs;      cs_p1   <= cs_p0;   cs_p2   <= cs_p1;
      mosi_p0 <= bus.spi_mosi; mosi_p1 <= mosi_p0; mosi_p2 <= mosi_p1;

      // cs high (which includes its rising edge) overrides any SPI edge in the same cycle
      if (cs_p1) begin
        state   <= IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
        active  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              in_sh   <= '0;
              out_sh  <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              in_sh   <= {in_sh[13:0], mosi_p2};
              bit_cnt <= byte_end ? '0 : bit_cnt + 1'b1;
              if (byte_end) begin
                if ({in_sh[6:0], mosi_p2} == 8'h03) begin
                  state <= ADDR_HI;
`ifdef LSPI_STATUS_EN
                end else if ({in_sh[6:0], mosi_p2} == 8'h05) begin
                  state  <= STAT;
                  out_sh <= DATA_W'({bus.busy, bus.frame_cnt}) << (DATA_W - 8);
`endif
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          ADDR_HI: begin
            if (sclk_rise) begin
              in_sh   <= {in_sh[13:0], mosi_p2};
              bit_cnt <= byte_end ? '0 : bit_cnt + 1'b1;
              if (byte_end) state <= ADDR_LO;
            end
          end
          ADDR_LO: begin
            if (sclk_rise) begin
              in_sh   <= {in_sh[13:0], mosi_p2};
              bit_cnt <= byte_end ? '0 : bit_cnt + 1'b1;
              if (byte_end) begin
                rdaddr <= ADDR_W'({in_sh, mosi_p2});
                state  <= DATA;
                active <= 1'b1;
              end
            end
          end
          DATA: begin
            // Word boundary: take the prefetched word and start fetching the next address.
            if (sclk_fall) begin
              if (bit_cnt == '0) begin
                miso   <= bus.rddata[DATA_W-1];
                out_sh <= {bus.rddata[DATA_W-2:0], 1'b0};
                rdaddr <= rdaddr + 1'b1;
              end else begin
                miso   <= out_sh[DATA_W-1];
                out_sh <= {out_sh[DATA_W-2:0], 1'b0};
              end
              bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
            end
          end
          STAT: begin
            // Zero fill after the status byte yields 0x00 for every later byte.
            if (sclk_fall) begin
              miso   <= out_sh[DATA_W-1];
              out_sh <= {out_sh[DATA_W-2:0], 1'b0};
            end
          end
          IGNORE: begin
            miso <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_spi_reader.sv
// Self-checking bench for line_spi_reader: directed plan cases plus randomized reads vs an SRAM array model.
// Expected STATUS response follows LSPI_STATUS_EN.
module tb_line_spi_reader;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int HALF   = 6;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  line_spi_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  line_spi_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus.slave)
  );

  // SRAM model: data appears on the 2nd clk edge after the address
  logic [DATA_W-1:0] mem [0:4095];
  logic [DATA_W-1:0] rd_p1;
  always @(posedge clk) begin
    rd_p1      <= mem[bus.rdaddr];
    bus.rddata <= rd_p1;
  end

  int   total = 0;
  int   bad   = 0;
  logic rx_q [$];
  logic act_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    bus.spi_mosi = b;
    repeat (HALF) @(negedge clk);
    bus.spi_clk = 1'b1;
    rx_q.push_back(bus.spi_miso);
    act_q.push_back(bus.active);
    repeat (HALF) @(negedge clk);
    bus.spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic clocks(input int n);
    for (int i = 0; i < n; i++) spi_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic spi_start();
    rx_q.delete();
    act_q.delete();
    bus.cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_stop(input string tag);
    repeat (HALF) @(negedge clk);
    bus.cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    chk({tag, "_idle_miso"}, 32'(bus.spi_miso), 32'd0);
    chk({tag, "_idle_active"}, 32'(bus.active), 32'd0);
  endtask

  function automatic logic [31:0] rx_field(input int first, input int nbits);
    logic [31:0] v = '0;
    for (int i = 0; i < nbits; i++) v = {v[30:0], rx_q[first + i]};
    return v;
  endfunction

  function automatic int count_ones(input int first, input int nbits, input bit use_act);
    int n = 0;
    for (int i = 0; i < nbits; i++) n += use_act ? int'(act_q[first + i]) : int'(rx_q[first + i]);
    return n;
  endfunction

  // Reference: READ returns 24 zero bits then mem[(start+k) mod 4096], start = low 12 address bits.
  task automatic do_read(input string tag, input logic [15:0] addr_bytes, input int nwords);
    int start;
    spi_start();
    send_byte(8'h03);
    send_byte(addr_bytes[15:8]);
    send_byte(addr_bytes[7:0]);
    clocks(nwords * DATA_W);
    start = int'(addr_bytes) % 4096;
    chk({tag, "_hdr_miso"}, 32'(count_ones(0, 24, 1'b0)), 32'd0);
    chk({tag, "_hdr_active"}, 32'(count_ones(0, 24, 1'b1)), 32'd0);
    chk({tag, "_data_active"}, 32'(count_ones(24, nwords * DATA_W, 1'b1)), 32'(nwords * DATA_W));
    for (int k = 0; k < nwords; k++)
      chk($sformatf("%s_w%0d", tag, k), rx_field(24 + k * DATA_W, DATA_W),
          32'(mem[(start + k) % 4096]));
    spi_stop(tag);
  endtask

  task automatic do_other(input string tag, input logic [7:0] cmd, input logic b,
                          input logic [6:0] fc, input logic [7:0] exp0);
    bus.busy = b;
    bus.frame_cnt = fc;
    spi_start();
    send_byte(cmd);
    clocks(16);
    chk({tag, "_b0"}, rx_field(8, 8), 32'(exp0));
    chk({tag, "_b1"}, rx_field(16, 8), 32'd0);
    chk({tag, "_active"}, 32'(count_ones(0, 24, 1'b1)), 32'd0);
    spi_stop(tag);
  endtask

  logic [7:0] stat_exp;
  logic [6:0] fc_r;
  logic       b_r;

  initial begin
    bus.spi_clk = 1'b0;
    bus.cs = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.busy = 1'b0;
    bus.frame_cnt = 7'd0;
    for (int i = 0; i < 4096; i++) mem[i] = DATA_W'($urandom);

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(bus.spi_miso), 32'd0);
    chk("rst_rdaddr", 32'(bus.rdaddr), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    res_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);

    mem[12'h010] = 16'hA55A;
    mem[12'h011] = 16'h1234;
    do_read("plan", 16'h0010, 2);

    mem[12'hFFF] = 16'hBEEF;
    mem[12'h000] = 16'hCAFE;
    do_read("wrap", 16'h0FFF, 2);

    do_read("upper", 16'hF005, 1);

`ifdef LSPI_STATUS_EN
    stat_exp = 8'hAA;
`else
    stat_exp = 8'h00;
`endif
    do_other("stat", 8'h05, 1'b1, 7'h2A, stat_exp);
    do_other("badcmd", 8'h9C, 1'b1, 7'h55, 8'h00);

    // abort after 5 address bits, then a full read
    spi_start();
    send_byte(8'h03);
    clocks(5);
    bus.cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    chk("abort_miso", 32'(bus.spi_miso), 32'd0);
    chk("abort_active", 32'(bus.active), 32'd0);
    do_read("after_abort", 16'h0020, 1);

    // reset in the middle of the data phase
    mem[12'h040] = 16'hFFFF;
    spi_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h40);
    clocks(5);
    repeat (HALF / 2) @(negedge clk);
    chk("pre_rst_miso", 32'(bus.spi_miso), 32'd1);
    chk("pre_rst_rdaddr", 32'(bus.rdaddr), 32'h041);
    chk("pre_rst_active", 32'(bus.active), 32'd1);
    res_n = 1'b0;
    #1;
    chk("mid_rst_miso", 32'(bus.spi_miso), 32'd0);
    chk("mid_rst_rdaddr", 32'(bus.rdaddr), 32'd0);
    chk("mid_rst_active", 32'(bus.active), 32'd0);
    bus.cs = 1'b1;
    repeat (4) @(negedge clk);
    res_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    do_read("post_rst", 16'h0040, 2);

    // randomized reads and status/ignore commands
    for (int t = 0; t < 6; t++) begin
      do_read($sformatf("rnd%0d", t), 16'($urandom), $urandom_range(1, 3));
    end
    for (int t = 0; t < 2; t++) begin
      b_r  = 1'($urandom);
      fc_r = 7'($urandom);
`ifdef LSPI_STATUS_EN
      stat_exp = {b_r, fc_r};
`else
      stat_exp = 8'h00;
`endif
      do_other($sformatf("rstat%0d", t), 8'h05, b_r, fc_r, stat_exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
